// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline interlock controller:
// FSM state encoding, register-zero constant and default counter width.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HALT   = 2'd1,
      RESUME = 2'd2
   } hazState_t;

   localparam logic [4:0]  REG_ZERO  = 5'd0;
   localparam int unsigned CNT_W_DEF = 32;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use stalls, redirect flushes,
// halt/resume sequencing and performance counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rAID,
   input  logic [4:0]       rBID,
   input  logic             rAValidID,
   input  logic             rBValidID,
   input  logic [4:0]       rWEX,
   input  logic             rW_enEX,
   input  logic             memToRegEX,
   input  logic             branchTakenEX,
   input  logic             jumpEX,
   input  logic             haltWB,
   input  logic             go,
   input  logic             clrCnt,
   output logic             stallPC,
   output logic             stallIFID,
   output logic             flushIFID,
   output logic             flushIDEX,
   output logic             holdBack,
   output logic             halted,
   output logic [CNT_W-1:0] cycleCnt,
   output logic [CNT_W-1:0] loadUseCnt,
   output logic [CNT_W-1:0] branchCnt
);

   hazState_t state, stateNext;
   logic      goPrev;
   logic      goRise;
   logic      loadUse;
   logic      redir;
   logic      hold;
   logic      loadUseApplied;
   logic      redirApplied;

   assign loadUse = memToRegEX && rW_enEX && (rWEX != REG_ZERO) &&
                    ((rAValidID && (rAID == rWEX)) || (rBValidID && (rBID == rWEX)));
   assign redir   = branchTakenEX || jumpEX;
   assign goRise  = go && !goPrev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         goPrev <= 1'b0;
      end else begin
         state  <= stateNext;
         goPrev <= go;
      end
   end

   // RESUME ignores haltWB so the halt instruction itself can retire.
   always_comb begin
      stateNext = state;
      hold      = 1'b0;
      case (state)
         RUN: begin
            if (haltWB) begin
               hold      = 1'b1;
               stateNext = HALT;
            end
         end
         HALT: begin
            hold = 1'b1;
            if (goRise) begin
               stateNext = RESUME;
            end
         end
         RESUME: begin
            stateNext = RUN;
         end
         default: begin
            stateNext = RUN;
         end
      endcase
   end

   // Redirect outranks load-use: the stalled ID instruction is wrong-path anyway.
   assign redirApplied   = !hold && redir;
   assign loadUseApplied = !hold && !redir && loadUse;

   assign stallPC   = hold || loadUseApplied;
   assign stallIFID = hold || loadUseApplied;
   assign flushIFID = redirApplied;
   assign flushIDEX = redirApplied || loadUseApplied;
   assign holdBack  = hold;
   assign halted    = (state == HALT);

   sat_counter #(.CNT_W(CNT_W)) uCycleCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clrCnt),
      .inc   (!hold),
      .q     (cycleCnt)
   );

   sat_counter #(.CNT_W(CNT_W)) uLoadUseCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clrCnt),
      .inc   (loadUseApplied),
      .q     (loadUseCnt)
   );

   sat_counter #(.CNT_W(CNT_W)) uBranchCnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clrCnt),
      .inc   (redirApplied),
      .q     (branchCnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with 4-bit counters to reach saturation quickly.
module tb_hazard_ctrl;

   localparam int unsigned CW = 4;

   logic          clk;
   logic          rst_n;
   logic [4:0]    rAID, rBID, rWEX;
   logic          rAValidID, rBValidID, rW_enEX, memToRegEX;
   logic          branchTakenEX, jumpEX, haltWB, go, clrCnt;
   logic          stallPC, stallIFID, flushIFID, flushIDEX, holdBack, halted;
   logic [CW-1:0] cycleCnt, loadUseCnt, branchCnt;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   hazard_ctrl #(.CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rAID          (rAID),
      .rBID          (rBID),
      .rAValidID     (rAValidID),
      .rBValidID     (rBValidID),
      .rWEX          (rWEX),
      .rW_enEX       (rW_enEX),
      .memToRegEX    (memToRegEX),
      .branchTakenEX (branchTakenEX),
      .jumpEX        (jumpEX),
      .haltWB        (haltWB),
      .go            (go),
      .clrCnt        (clrCnt),
      .stallPC       (stallPC),
      .stallIFID     (stallIFID),
      .flushIFID     (flushIFID),
      .flushIDEX     (flushIDEX),
      .holdBack      (holdBack),
      .halted        (halted),
      .cycleCnt      (cycleCnt),
      .loadUseCnt    (loadUseCnt),
      .branchCnt     (branchCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic idleInputs();
      rAID = '0; rBID = '0; rWEX = '0;
      rAValidID = 1'b0; rBValidID = 1'b0; rW_enEX = 1'b0; memToRegEX = 1'b0;
      branchTakenEX = 1'b0; jumpEX = 1'b0; haltWB = 1'b0; clrCnt = 1'b0;
   endtask

   task automatic loadUseVec();
      rWEX = 5'd5; memToRegEX = 1'b1; rW_enEX = 1'b1; rAID = 5'd5; rAValidID = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkComb(input string tag, input logic [4:0] exp);
      checkVal({tag, "_comb"}, {27'd0, stallPC, stallIFID, flushIFID, flushIDEX, holdBack},
               {27'd0, exp});
   endtask

   initial begin
      idleInputs();
      go    = 1'b0;
      rst_n = 1'b0;
      #3;
      checkVal("rst_halted", 32'(halted), 32'd0);
      checkVal("rst_cycle", 32'(cycleCnt), 32'd0);
      checkVal("rst_lu", 32'(loadUseCnt), 32'd0);
      checkVal("rst_br", 32'(branchCnt), 32'd0);
      checkComb("rst", 5'b00000);
      #19;
      rst_n = 1'b1;

      // load-use: {stallPC, stallIFID, flushIFID, flushIDEX, holdBack}
      loadUseVec();
      #1 checkComb("loaduse", 5'b11010);
      tick();
      checkVal("loaduse_cnt", 32'(loadUseCnt), 32'd1);
      checkVal("loaduse_cyc", 32'(cycleCnt), 32'd1);

      rWEX = 5'd0; rAID = 5'd0;
      #1 checkComb("rzero", 5'b00000);
      rWEX = 5'd5; rAID = 5'd1; rAValidID = 1'b0; rBID = 5'd5; rBValidID = 1'b0;
      #1 checkComb("rb_invalid", 5'b00000);
      rBValidID = 1'b1;
      #1 checkComb("rb_valid", 5'b11010);
      idleInputs();
      tick();
      checkVal("noluse_cnt", 32'(loadUseCnt), 32'd1);

      loadUseVec(); branchTakenEX = 1'b1;
      #1 checkComb("redir_prio", 5'b00110);
      tick();
      checkVal("redir_br", 32'(branchCnt), 32'd1);
      checkVal("redir_lu", 32'(loadUseCnt), 32'd1);

      idleInputs(); jumpEX = 1'b1;
      #1 checkComb("jump", 5'b00110);
      tick();
      checkVal("jump_br", 32'(branchCnt), 32'd2);
      checkVal("jump_cyc", 32'(cycleCnt), 32'd4);

      // halt with a simultaneous taken branch: hold masks the flush
      idleInputs(); haltWB = 1'b1; branchTakenEX = 1'b1;
      #1 checkComb("halt_entry", 5'b11001);
      checkVal("halt_entry_halted", 32'(halted), 32'd0);
      tick();
      checkVal("halted_set", 32'(halted), 32'd1);
      for (int i = 0; i < 10; i++) tick();
      checkVal("halt_cyc_frozen", 32'(cycleCnt), 32'd4);
      checkVal("halt_br_frozen", 32'(branchCnt), 32'd2);
      checkComb("halt_hold", 5'b11001);

      branchTakenEX = 1'b0; go = 1'b1;
      #1 checkComb("halt_go", 5'b11001);
      tick();
      checkVal("resume_halted", 32'(halted), 32'd0);
      checkComb("resume", 5'b00000);
      tick();
      checkVal("run_after_resume", 32'(halted), 32'd0);
      checkVal("resume_cyc", 32'(cycleCnt), 32'd5);
      haltWB = 1'b0;
      tick();
      haltWB = 1'b1;
      tick();
      haltWB = 1'b0;
      checkVal("rehalt", 32'(halted), 32'd1);
      tick();
      tick();
      checkVal("go_level_no_resume", 32'(halted), 32'd1);
      checkVal("rehalt_cyc", 32'(cycleCnt), 32'd6);
      go = 1'b0;
      tick();
      go = 1'b1;
      tick();
      checkVal("second_resume", 32'(halted), 32'd0);
      tick();
      checkVal("second_resume_cyc", 32'(cycleCnt), 32'd7);
      go = 1'b0;

      clrCnt = 1'b1;
      tick();
      clrCnt = 1'b0;
      checkVal("clr_cyc", 32'(cycleCnt), 32'd0);
      checkVal("clr_lu", 32'(loadUseCnt), 32'd0);
      checkVal("clr_br", 32'(branchCnt), 32'd0);
      for (int i = 0; i < 14; i++) tick();
      checkVal("cyc_14", 32'(cycleCnt), 32'd14);
      for (int i = 0; i < 6; i++) tick();
      checkVal("cyc_sat", 32'(cycleCnt), 32'd15);

      loadUseVec(); clrCnt = 1'b1;
      tick();
      checkVal("clr_prio_cyc", 32'(cycleCnt), 32'd0);
      checkVal("clr_prio_lu", 32'(loadUseCnt), 32'd0);
      clrCnt = 1'b0;
      tick();
      checkVal("post_clr_lu", 32'(loadUseCnt), 32'd1);

      idleInputs(); haltWB = 1'b1;
      tick();
      haltWB = 1'b0;
      checkVal("pre_rst_halted", 32'(halted), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkVal("arst_halted", 32'(halted), 32'd0);
      checkVal("arst_cyc", 32'(cycleCnt), 32'd0);
      checkVal("arst_lu", 32'(loadUseCnt), 32'd0);
      checkComb("arst_run", 5'b00000);
      #5 rst_n = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
